// File: rtl/noc_pkg.sv
// Shared definitions for the NoC virtual-channel input buffer: flit type codes,
// default field geometry, packet FSM states and a compile-time clog2.
package noc_pkg;

    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    localparam int unsigned NOC_FLIT_W   = 32;
    localparam int unsigned NOC_DEST_LSB = 8;
    localparam int unsigned NOC_DEST_W   = 4;

    typedef enum logic {
        StIdle,
        StActive
    } pkt_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/noc_vc_input_buffer_if.sv
// Write/read handshake bundle of the VC input buffer. The err signal exists only when
// NOC_VC_PROTOCOL_CHECK_EN is defined.
interface noc_vc_input_buffer_if
    import noc_pkg::*;
#(
    parameter int unsigned FLIT_W = NOC_FLIT_W,
    parameter int unsigned NUM_VC = 2,
    parameter int unsigned DEST_W = NOC_DEST_W
);
    localparam int unsigned VC_W = (NUM_VC > 1) ? clog2(NUM_VC) : 1;

    logic              wr_en;
    logic [VC_W-1:0]   wr_vc;
    logic [FLIT_W-1:0] wr_flit;
    logic              rd_en;
    logic [VC_W-1:0]   rd_vc;
    logic              rd_valid;
    logic [FLIT_W-1:0] rd_flit;
    logic [DEST_W-1:0] rd_dest;
    logic [NUM_VC-1:0] empty;
    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] pkt_active;
    logic [NUM_VC-1:0] credit_out;

`ifdef NOC_VC_PROTOCOL_CHECK_EN
    logic [NUM_VC-1:0] err;

    modport master (
        output wr_en, wr_vc, wr_flit, rd_en, rd_vc,
        input  rd_valid, rd_flit, rd_dest, empty, full, pkt_active, credit_out, err
    );

    modport slave (
        input  wr_en, wr_vc, wr_flit, rd_en, rd_vc,
        output rd_valid, rd_flit, rd_dest, empty, full, pkt_active, credit_out, err
    );
`else
    modport master (
        output wr_en, wr_vc, wr_flit, rd_en, rd_vc,
        input  rd_valid, rd_flit, rd_dest, empty, full, pkt_active, credit_out
    );

    modport slave (
        input  wr_en, wr_vc, wr_flit, rd_en, rd_vc,
        output rd_valid, rd_flit, rd_dest, empty, full, pkt_active, credit_out
    );
`endif

endinterface

// File: rtl/noc_vc_queue.sv
// Single-VC circular flit queue. push/pop must already be qualified by !full/!empty;
// the head entry is presented combinationally on rdata.
module noc_vc_queue
    import noc_pkg::*;
#(
    parameter int unsigned FLIT_W = NOC_FLIT_W,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [FLIT_W-1:0] wdata,
    output logic [FLIT_W-1:0] rdata,
    output logic              empty,
    output logic              full
);
    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

endmodule

// File: rtl/noc_vc_input_buffer.sv
// Mesh router input port buffer: NUM_VC queues, registered pop, per-VC packet dest tracking
// and credit pulses. Define NOC_VC_PROTOCOL_CHECK_EN to drop mis-framed writes and flag err.
module noc_vc_input_buffer
    import noc_pkg::*;
#(
    parameter int unsigned FLIT_W   = NOC_FLIT_W,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned NUM_VC   = 2,
    parameter int unsigned DEST_LSB = NOC_DEST_LSB,
    parameter int unsigned DEST_W   = NOC_DEST_W
) (
    input logic                  clk,
    input logic                  rst_n,
    noc_vc_input_buffer_if.slave bus
);
    logic [NUM_VC-1:0] q_empty;
    logic [NUM_VC-1:0] q_full;
    logic [NUM_VC-1:0] q_push;
    logic [NUM_VC-1:0] q_pop;
    logic [FLIT_W-1:0] q_rdata [NUM_VC];

    logic              wr_cand;
    logic              wr_violation;
    logic              rd_accept;
    logic [FLIT_W-1:0] rd_head;
    logic [1:0]        rd_type;
    logic [DEST_W-1:0] rd_head_dest;

    logic              rd_valid_q;
    logic [FLIT_W-1:0] rd_flit_q;
    logic [DEST_W-1:0] rd_dest_q;
    logic [NUM_VC-1:0] credit_q;
    logic [NUM_VC-1:0] pkt_active;
    pkt_state_e        rd_state_q [NUM_VC];
    logic [DEST_W-1:0] dest_q     [NUM_VC];

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        noc_vc_queue #(
            .FLIT_W(FLIT_W),
            .DEPTH (DEPTH)
        ) u_queue (
            .clk  (clk),
            .rst_n(rst_n),
            .push (q_push[v]),
            .pop  (q_pop[v]),
            .wdata(bus.wr_flit),
            .rdata(q_rdata[v]),
            .empty(q_empty[v]),
            .full (q_full[v])
        );
    end

    // Full/empty are pre-edge values, so a pop never frees room for a same-cycle write.
    assign wr_cand   = bus.wr_en && (32'(bus.wr_vc) < NUM_VC) && !q_full[bus.wr_vc];
    assign rd_accept = bus.rd_en && (32'(bus.rd_vc) < NUM_VC) && !q_empty[bus.rd_vc];

    assign rd_head      = q_rdata[bus.rd_vc];
    assign rd_type      = rd_head[FLIT_W-1 -: 2];
    assign rd_head_dest = rd_head[DEST_LSB +: DEST_W];

`ifdef NOC_VC_PROTOCOL_CHECK_EN
    pkt_state_e        wr_state_q [NUM_VC];
    logic [NUM_VC-1:0] err_q;
    logic [1:0]        wr_type;

    assign wr_type = bus.wr_flit[FLIT_W-1 -: 2];

    always_comb begin
        wr_violation = 1'b0;
        if (wr_state_q[bus.wr_vc] == StIdle) begin
            wr_violation = (wr_type == FT_BODY) || (wr_type == FT_TAIL);
        end else begin
            wr_violation = (wr_type == FT_HEAD) || (wr_type == FT_SINGLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
            for (int v = 0; v < NUM_VC; v++) wr_state_q[v] <= StIdle;
        end else if (wr_cand) begin
            if (wr_violation) begin
                err_q[bus.wr_vc] <= 1'b1;
            end else if (wr_type == FT_HEAD) begin
                wr_state_q[bus.wr_vc] <= StActive;
            end else if (wr_type == FT_TAIL) begin
                wr_state_q[bus.wr_vc] <= StIdle;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign wr_violation = 1'b0;
`endif

    always_comb begin
        q_push = '0;
        q_pop  = '0;
        if (wr_cand && !wr_violation) q_push[bus.wr_vc] = 1'b1;
        if (rd_accept)                q_pop[bus.rd_vc]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_flit_q  <= '0;
            rd_dest_q  <= '0;
            credit_q   <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                rd_state_q[v] <= StIdle;
                dest_q[v]     <= '0;
            end
        end else begin
            rd_valid_q <= rd_accept;
            credit_q   <= q_pop;
            if (rd_accept) begin
                rd_flit_q <= rd_head;
                // Head-carrying flits supply their own dest; the rest inherit the packet's.
                rd_dest_q <= (rd_type == FT_HEAD || rd_type == FT_SINGLE) ?
                             rd_head_dest : dest_q[bus.rd_vc];
                if (rd_state_q[bus.rd_vc] == StIdle && rd_type == FT_HEAD) begin
                    rd_state_q[bus.rd_vc] <= StActive;
                    dest_q[bus.rd_vc]     <= rd_head_dest;
                end else if (rd_state_q[bus.rd_vc] == StActive && rd_type == FT_TAIL) begin
                    rd_state_q[bus.rd_vc] <= StIdle;
                end
            end
        end
    end

    always_comb begin
        pkt_active = '0;
        for (int v = 0; v < NUM_VC; v++) pkt_active[v] = (rd_state_q[v] == StActive);
    end

    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_flit    = rd_flit_q;
    assign bus.rd_dest    = rd_dest_q;
    assign bus.credit_out = credit_q;
    assign bus.pkt_active = pkt_active;
    assign bus.empty      = q_empty;
    assign bus.full       = q_full;

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Directed self-checking bench for noc_vc_input_buffer (DEPTH=8, NUM_VC=2).
module tb_noc_vc_input_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    noc_vc_input_buffer_if #(.FLIT_W(32), .NUM_VC(2), .DEST_W(4)) bus ();

    noc_vc_input_buffer #(
        .FLIT_W  (32),
        .DEPTH   (8),
        .NUM_VC  (2),
        .DEST_LSB(8),
        .DEST_W  (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_flit(input logic vc, input logic [31:0] flit);
        bus.wr_en   = 1'b1;
        bus.wr_vc   = vc;
        bus.wr_flit = flit;
        cycle();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pop_one(input logic vc);
        bus.rd_en = 1'b1;
        bus.rd_vc = vc;
        cycle();
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        total++; if (bus.empty !== 2'b11) $display("FAIL reset_empty got %b want 11", bus.empty); else passed++;
        total++; if (bus.full !== 2'b00) $display("FAIL reset_full got %b want 00", bus.full); else passed++;
        total++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); else passed++;
        total++; if (bus.rd_flit !== 32'h0) $display("FAIL reset_rd_flit got %h want 0", bus.rd_flit); else passed++;
        total++; if (bus.rd_dest !== 4'h0) $display("FAIL reset_rd_dest got %h want 0", bus.rd_dest); else passed++;
        total++; if (bus.credit_out !== 2'b00) $display("FAIL reset_credit got %b want 00", bus.credit_out); else passed++;
        total++; if (bus.pkt_active !== 2'b00) $display("FAIL reset_pkt_active got %b want 00", bus.pkt_active); else passed++;
`ifdef NOC_VC_PROTOCOL_CHECK_EN
        total++; if (bus.err !== 2'b00) $display("FAIL reset_err got %b want 00", bus.err); else passed++;
`endif
        #2 rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_packet();
        write_flit(1'b0, 32'h4000_0300);
        total++; if (bus.empty[0] !== 1'b0) $display("FAIL pkt_write_visible got %b want 0", bus.empty[0]); else passed++;
        write_flit(1'b0, 32'h0000_0011);
        write_flit(1'b0, 32'h8000_0022);
        pop_one(1'b0);
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_flit !== 32'h4000_0300) $display("FAIL pkt_head got v=%b %h want v=1 40000300", bus.rd_valid, bus.rd_flit); else passed++;
        total++; if (bus.rd_dest !== 4'h3 || bus.pkt_active[0] !== 1'b1) $display("FAIL pkt_head_dest got d=%h act=%b want d=3 act=1", bus.rd_dest, bus.pkt_active[0]); else passed++;
        total++; if (bus.credit_out !== 2'b01) $display("FAIL pkt_credit0 got %b want 01", bus.credit_out); else passed++;
        pop_one(1'b0);
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_flit !== 32'h0000_0011 || bus.rd_dest !== 4'h3) $display("FAIL pkt_body got v=%b %h d=%h want v=1 00000011 d=3", bus.rd_valid, bus.rd_flit, bus.rd_dest); else passed++;
        total++; if (bus.credit_out !== 2'b01 || bus.pkt_active[0] !== 1'b1) $display("FAIL pkt_body_state got cr=%b act=%b want cr=01 act=1", bus.credit_out, bus.pkt_active[0]); else passed++;
        pop_one(1'b0);
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_flit !== 32'h8000_0022 || bus.rd_dest !== 4'h3) $display("FAIL pkt_tail got v=%b %h d=%h want v=1 80000022 d=3", bus.rd_valid, bus.rd_flit, bus.rd_dest); else passed++;
        total++; if (bus.credit_out !== 2'b01 || bus.pkt_active[0] !== 1'b0) $display("FAIL pkt_tail_state got cr=%b act=%b want cr=01 act=0", bus.credit_out, bus.pkt_active[0]); else passed++;
        cycle();
        total++; if (bus.rd_valid !== 1'b0 || bus.credit_out !== 2'b00 || bus.rd_flit !== 32'h8000_0022) $display("FAIL pkt_idle got v=%b cr=%b %h want v=0 cr=00 80000022", bus.rd_valid, bus.credit_out, bus.rd_flit); else passed++;
        total++; if (bus.empty[0] !== 1'b1) $display("FAIL pkt_drained got %b want 1", bus.empty[0]); else passed++;
    endtask

    task automatic test_full();
        logic [31:0] exp_flits [8];
        for (int i = 0; i < 8; i++) begin
            exp_flits[i] = (i == 0) ? 32'h4000_0A00 : (i == 7) ? 32'h8000_00C7 : 32'h0000_00B0 + i;
        end
        for (int i = 0; i < 7; i++) write_flit(1'b1, exp_flits[i]);
        total++; if (bus.full[1] !== 1'b0) $display("FAIL full_at7 got %b want 0", bus.full[1]); else passed++;
        write_flit(1'b1, exp_flits[7]);
        total++; if (bus.full !== 2'b10) $display("FAIL full_at8 got %b want 10", bus.full); else passed++;
        write_flit(1'b1, 32'h4000_0D99);
        total++; if (bus.full[1] !== 1'b1) $display("FAIL full_after_drop got %b want 1", bus.full[1]); else passed++;
        bus.wr_en   = 1'b1;
        bus.wr_vc   = 1'b1;
        bus.wr_flit = 32'h4000_0E55;
        pop_one(1'b1);
        bus.wr_en   = 1'b0;
        total++; if (bus.rd_flit !== exp_flits[0] || bus.rd_dest !== 4'hA) $display("FAIL full_wrpop_head got %h d=%h want %h d=a", bus.rd_flit, bus.rd_dest, exp_flits[0]); else passed++;
        total++; if (bus.full[1] !== 1'b0 || bus.credit_out !== 2'b10) $display("FAIL full_wrpop_state got f=%b cr=%b want f=0 cr=10", bus.full[1], bus.credit_out); else passed++;
        for (int i = 1; i < 8; i++) begin
            pop_one(1'b1);
            total++; if (bus.rd_valid !== 1'b1 || bus.rd_flit !== exp_flits[i]) $display("FAIL full_order%0d got v=%b %h want v=1 %h", i, bus.rd_valid, bus.rd_flit, exp_flits[i]); else passed++;
        end
        total++; if (bus.empty[1] !== 1'b1 || bus.pkt_active[1] !== 1'b0) $display("FAIL full_drained got e=%b act=%b want e=1 act=0", bus.empty[1], bus.pkt_active[1]); else passed++;
        cycle();
    endtask

    task automatic test_interleave();
        logic        vcs   [4];
        logic [31:0] flits [4];
        logic [3:0]  dests [4];
        vcs[0] = 1'b0; flits[0] = 32'h4000_0500; dests[0] = 4'h5;
        vcs[1] = 1'b1; flits[1] = 32'h4000_0900; dests[1] = 4'h9;
        vcs[2] = 1'b0; flits[2] = 32'h8000_0001; dests[2] = 4'h5;
        vcs[3] = 1'b1; flits[3] = 32'h8000_0002; dests[3] = 4'h9;
        for (int i = 0; i < 4; i++) write_flit(vcs[i], flits[i]);
        for (int i = 0; i < 4; i++) begin
            pop_one(vcs[i]);
            total++; if (bus.rd_flit !== flits[i] || bus.rd_dest !== dests[i]) $display("FAIL ilv_pop%0d got %h d=%h want %h d=%h", i, bus.rd_flit, bus.rd_dest, flits[i], dests[i]); else passed++;
            total++; if (bus.credit_out !== (vcs[i] ? 2'b10 : 2'b01)) $display("FAIL ilv_credit%0d got %b want vc %0d", i, bus.credit_out, vcs[i]); else passed++;
        end
        total++; if (bus.pkt_active !== 2'b00) $display("FAIL ilv_end_active got %b want 00", bus.pkt_active); else passed++;
        cycle();
    endtask

    task automatic test_single();
        write_flit(1'b0, 32'hC000_0700);
        pop_one(1'b0);
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_dest !== 4'h7) $display("FAIL single_dest got v=%b d=%h want v=1 d=7", bus.rd_valid, bus.rd_dest); else passed++;
        total++; if (bus.pkt_active !== 2'b00) $display("FAIL single_active got %b want 00", bus.pkt_active); else passed++;
        cycle();
    endtask

    task automatic test_reset_mid_packet();
        write_flit(1'b0, 32'h4000_0300);
        write_flit(1'b0, 32'h0000_0011);
        write_flit(1'b0, 32'h8000_0022);
        pop_one(1'b0);
        total++; if (bus.pkt_active[0] !== 1'b1) $display("FAIL rstmid_pre_active got %b want 1", bus.pkt_active[0]); else passed++;
        rst_n = 1'b0;
        #2;
        total++; if (bus.empty[0] !== 1'b1 || bus.pkt_active[0] !== 1'b0) $display("FAIL rstmid_cleared got e=%b act=%b want e=1 act=0", bus.empty[0], bus.pkt_active[0]); else passed++;
        total++; if (bus.credit_out !== 2'b00 || bus.rd_valid !== 1'b0) $display("FAIL rstmid_outputs got cr=%b v=%b want cr=00 v=0", bus.credit_out, bus.rd_valid); else passed++;
        rst_n = 1'b1;
        bus.rd_en = 1'b1;
        bus.rd_vc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++; if (bus.credit_out !== 2'b00 || bus.rd_valid !== 1'b0) $display("FAIL rstmid_no_credit%0d got cr=%b v=%b want cr=00 v=0", i, bus.credit_out, bus.rd_valid); else passed++;
        end
        bus.rd_en = 1'b0;
    endtask

`ifdef NOC_VC_PROTOCOL_CHECK_EN
    task automatic test_protocol();
        write_flit(1'b0, 32'h0000_0055);
        total++; if (bus.empty[0] !== 1'b1) $display("FAIL proto_dropped got %b want 1", bus.empty[0]); else passed++;
        total++; if (bus.err !== 2'b01) $display("FAIL proto_err got %b want 01", bus.err); else passed++;
        write_flit(1'b0, 32'hC000_0100);
        total++; if (bus.err !== 2'b01 || bus.empty[0] !== 1'b0) $display("FAIL proto_sticky got err=%b e=%b want err=01 e=0", bus.err, bus.empty[0]); else passed++;
        rst_n = 1'b0;
        #2;
        total++; if (bus.err !== 2'b00) $display("FAIL proto_err_reset got %b want 00", bus.err); else passed++;
        rst_n = 1'b1;
        cycle();
    endtask
`endif

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_vc   = 1'b0;
        bus.wr_flit = 32'h0;
        bus.rd_en   = 1'b0;
        bus.rd_vc   = 1'b0;
        test_reset();
        test_packet();
        test_full();
        test_interleave();
        test_single();
        test_reset_mid_packet();
`ifdef NOC_VC_PROTOCOL_CHECK_EN
        test_protocol();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/noc_vc_input_buffer.md
# noc_vc_input_buffer

Parametrised input buffer for a mesh router port that holds flits in NUM_VC independent circular queues, one per virtual channel. It sits between the link receiver and the router's XY route-compute/switch-allocation stage. It adds four things a single-queue port buffer lacks: per-VC storage, a registered pop with valid, per-VC packet tracking that holds the head flit's destination for the whole packet, and a per-VC credit pulse to the upstream router.

## Interface
- FLIT_W, 32: flit width; bits [FLIT_W-1:FLIT_W-2] are flit type.
- DEPTH, 8: entries per VC; power of 2, ≥2.
- NUM_VC, 2: number of virtual channels, ≥1.
- DEST_LSB, 8: LSB of the destination field in a head flit.
- DEST_W, 4: destination field width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write request.
- wr_vc  in  VC_W  target VC. VC_W = max(1, clog2(NUM_VC)).
- wr_flit  in  FLIT_W  flit to store.
- rd_en  in  1  pop request.
- rd_vc  in  VC_W  VC to pop.
- rd_valid  out  1  rd_flit/rd_dest valid this cycle.
- rd_flit  out  FLIT_W  popped flit.
- rd_dest  out  DEST_W  destination of the packet that rd_flit belongs to.
- empty  out  NUM_VC  per-VC empty.
- full  out  NUM_VC  per-VC full.
- pkt_active  out  NUM_VC  a head has been popped from this VC and its tail has not.
- credit_out  out  NUM_VC  one-cycle pulse per freed entry.
- err  out  NUM_VC  sticky protocol error; exists only with the configuration macro.

## Operation
- Flit type codes: 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 SINGLE (head and tail in one flit).
- Write is accepted when wr_en && !full[wr_vc] at the clock edge. The flit is stored at wr_ptr[wr_vc], then that pointer increments. Writes to a full VC are silently dropped.
- Pop is accepted when rd_en && !empty[rd_vc] at the clock edge. On acceptance, rd_ptr[rd_vc] increments. A pop of an empty VC is ignored.
- Pointers wrap modulo DEPTH. The per-VC count is clog2(DEPTH)+1 bits wide.
  - empty = (count == 0).
  - full = (count == DEPTH).
- Simultaneous accepted write and pop on the same VC leave the count unchanged. full and empty are evaluated before the edge, so a write to a full VC is rejected even when that VC is popped in the same cycle.
- Per-VC read-side packet FSM has two states, IDLE and ACTIVE. Transitions on accepted pops:
  - IDLE: pop HEAD → ACTIVE; latch dest_reg[vc] = flit[DEST_LSB+:DEST_W].
  - ACTIVE: pop TAIL → IDLE.
  - SINGLE: state unchanged.
  - BODY: state unchanged.
- pkt_active[vc] = (state == ACTIVE).
- rd_dest selection:
  - For a HEAD or SINGLE pop, rd_dest is the field taken from the flit itself.
  - For a BODY or TAIL pop, rd_dest is dest_reg of that VC.
- Reset values:
  - rd_valid=0, rd_flit=0, rd_dest=0, credit_out=0, pkt_active=0, full=0, err=0.
  - empty = all ones.
  - All pointers, counts and FSMs cleared.
  - Memory contents are not reset.
- Reset asserted mid-packet discards all queued flits and returns every FSM to IDLE. No credits are issued for discarded flits.

## Timing
- Write-to-visible latency is 1 cycle: empty[vc] deasserts in the cycle after the accepting edge.
- Pop latency is 1 cycle. rd_valid, rd_flit, rd_dest and credit_out[rd_vc] are registered and asserted for exactly one cycle after the accepting edge.
- Back-to-back pops of one VC, one per cycle, yield a continuous rd_valid.
- When no pop is accepted, rd_valid is 0 and rd_flit/rd_dest hold their last values.
- full[vc] asserts in the cycle after the DEPTH-th outstanding write is accepted.

## Configuration
- NOC_VC_PROTOCOL_CHECK_EN, defined: a per-VC write-side FSM, also IDLE/ACTIVE, checks framing on accepted-candidate writes.
  - Violations: BODY or TAIL written while the write FSM is IDLE; HEAD or SINGLE written while it is ACTIVE.
  - A violating flit is dropped: it is not stored, no pointer moves, and err[vc] is set. err clears only on reset.
- NOC_VC_PROTOCOL_CHECK_EN, undefined: every non-full write is stored regardless of type, and the err port is absent.

## Structure
- Shared package noc_pkg:
  - Flit-type localparams FT_HEAD, FT_BODY, FT_TAIL, FT_SINGLE.
  - Default FLIT_W/DEST_LSB/DEST_W constants.
  - Compile-time clog2 function.
- Sub-module noc_vc_queue: a single-VC circular buffer holding mem, pointers, count, empty and full. It is instantiated NUM_VC times.
- The top level holds the VC write/read demux, the read-side output register, the packet FSMs and credit generation.

## Test plan
- Reset, then write HEAD 32'h4000_0300 plus BODY 32'h0000_0011 plus TAIL 32'h8000_0022 to VC0, then pop 3 consecutive cycles → rd_valid high 3 cycles; rd_dest=3 on all three; pkt_active[0] goes 1 then 0; 3 credit_out[0] pulses.
- Fill VC1 with 8 flits (DEPTH=8) → full[1]=1; 9th write dropped. Write and pop VC1 in the same cycle → the write is still dropped. Popping all 8 returns the original order.
- Interleave packets: VC0 dest 5 and VC1 dest 9, with pops alternating VCs → each flit's rd_dest matches its own VC's head.
- SINGLE flit 32'hC000_0700 popped → rd_dest=7; pkt_active stays 0.
- Assert rst_n low after popping a HEAD on VC0 with 2 flits still queued → empty[0]=1, pkt_active[0]=0, no credit pulses.
- With NOC_VC_PROTOCOL_CHECK_EN, write BODY to an idle VC0 → not stored, empty[0] stays 1, err[0]=1 until reset.
